// File: rtl/irr_priority_resolver.sv
// irr_priority_resolver
// Front end of the 8259A in-service block: synchronises the IR pins, latches
// requests into the IRR (edge or level sensed), masks them, and resolves the
// single highest-priority eligible request against the in-service register
// under fixed or rotated priority. Winner and INT are registered.
module irr_priority_resolver #(
    parameter int NUM_IR = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_IR-1:0] ir_in,
    input  logic              level_or_edge,
    input  logic [NUM_IR-1:0] interrupt_mask,
    input  logic              special_mask_mode,
    input  logic [NUM_IR-1:0] in_service_register,
    input  logic [NUM_IR-1:0] clear_request,
    input  logic              priority_load,
    input  logic [2:0]        priority_level,
    input  logic              freeze,
    output logic [NUM_IR-1:0] interrupt_request_register,
    output logic [NUM_IR-1:0] highest_priority_interrupt,
    output logic              interrupt
);

    logic [NUM_IR-1:0] ir_sync_p0;
    logic [NUM_IR-1:0] ir_prev_p0;
    logic              primed_p0;
    logic [NUM_IR-1:0] irr_p1;
    logic [2:0]        lowest_ptr;
    logic [NUM_IR-1:0] resolved;
    logic [NUM_IR-1:0] hpi_p2;
    logic              int_p2;

    // Rank of the highest-priority set bit of vec (0 = top priority), or
    // NUM_IR when vec is empty. Rank of level L is (L - ptr - 1) mod 8.
    function automatic logic [3:0] priority_rank(input logic [NUM_IR-1:0] vec,
                                                 input logic [2:0]        ptr);
        logic [3:0] rank;
        logic [2:0] lvl;
        rank = 4'(NUM_IR);
        for (int i = NUM_IR - 1; i >= 0; i--) begin
            lvl = ptr + 3'd1 + 3'(i);
            if (vec[lvl]) rank = 4'(i);
        end
        return rank;
    endfunction

    // One-hot winner, or zero when nothing is eligible.
    function automatic logic [NUM_IR-1:0] resolve(input logic [NUM_IR-1:0] irr,
                                                  input logic [NUM_IR-1:0] mask,
                                                  input logic [NUM_IR-1:0] isr,
                                                  input logic              smm,
                                                  input logic [2:0]        ptr);
        logic [NUM_IR-1:0] req;
        logic [NUM_IR-1:0] one_hot;
        logic [3:0]        req_rank;
        logic [3:0]        isr_rank;
        logic [2:0]        lvl;
        req = irr & ~mask;
        if (smm) req = req & ~isr;
        req_rank = priority_rank(req, ptr);
        // In special mask mode in-service levels only hide themselves.
        isr_rank = smm ? 4'(NUM_IR) : priority_rank(isr, ptr);
        one_hot  = '0;
        if (req_rank < isr_rank) begin
            lvl          = ptr + 3'd1 + req_rank[2:0];
            one_hot[lvl] = 1'b1;
        end
        return one_hot;
    endfunction

    // Input synchroniser and previous-sample history for edge detection.
    // ir_prev starts all ones and is only loaded once ir_sync holds a real
    // pin sample, so a line high through reset is never seen as rising.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_sync_p0 <= '0;
            ir_prev_p0 <= '1;
            primed_p0  <= 1'b0;
        end else begin
            ir_sync_p0 <= ir_in;
            if (primed_p0) ir_prev_p0 <= ir_sync_p0;
            primed_p0  <= 1'b1;
        end
    end

    // ---- stage p1: request latch ----
    // Edge mode: clear wins, a low pin drops the request, a rising edge sets it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irr_p1 <= '0;
        end else if (level_or_edge) begin
            irr_p1 <= ir_sync_p0 & ~clear_request;
        end else begin
            irr_p1 <= ~clear_request & ir_sync_p0 & (irr_p1 | ~ir_prev_p0);
        end
    end

    // Lowest-priority pointer; loads even while the outputs are frozen.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lowest_ptr <= 3'd7;
        end else if (priority_load) begin
            lowest_ptr <= priority_level;
        end
    end

    // Combinational priority resolution against the current ISR.
    always_comb begin
        resolved = resolve(irr_p1, interrupt_mask, in_service_register,
                           special_mask_mode, lowest_ptr);
    end

    // ---- stage p2: registered winner and INT, held during freeze ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hpi_p2 <= '0;
            int_p2 <= 1'b0;
        end else if (!freeze) begin
            hpi_p2 <= resolved;
            int_p2 <= |resolved;
        end
    end

    assign interrupt_request_register = irr_p1;
    assign highest_priority_interrupt = hpi_p2;
    assign interrupt                  = int_p2;

endmodule

// File: tb/tb_irr_priority_resolver.sv
// Testbench for irr_priority_resolver: directed scenarios plus a randomized
// run compared against a behavioural model of the request/priority rules.
module tb_irr_priority_resolver;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [7:0] ir_in = '0;
    logic       level_or_edge = 1'b0;
    logic [7:0] interrupt_mask = '0;
    logic       special_mask_mode = 1'b0;
    logic [7:0] in_service_register = '0;
    logic [7:0] clear_request = '0;
    logic       priority_load = 1'b0;
    logic [2:0] priority_level = '0;
    logic       freeze = 1'b0;
    logic [7:0] interrupt_request_register;
    logic [7:0] highest_priority_interrupt;
    logic       interrupt;

    int checks = 0;
    int failures = 0;

    irr_priority_resolver #(.NUM_IR(8)) dut (
        .clk                        (clk),
        .reset_n                    (reset_n),
        .ir_in                      (ir_in),
        .level_or_edge              (level_or_edge),
        .interrupt_mask             (interrupt_mask),
        .special_mask_mode          (special_mask_mode),
        .in_service_register        (in_service_register),
        .clear_request              (clear_request),
        .priority_load              (priority_load),
        .priority_level             (priority_level),
        .freeze                     (freeze),
        .interrupt_request_register (interrupt_request_register),
        .highest_priority_interrupt (highest_priority_interrupt),
        .interrupt                  (interrupt)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    // Pin samples taken since reset: last = most recent, older = one before.
    logic [7:0] m_last, m_older;
    int         m_nsamp;
    logic [7:0] m_irr, m_hpi;
    logic       m_int;
    int         m_ptr;

    // Priority number of a level: 0 is highest, (level - ptr - 1) mod 8.
    function automatic int prio_of(input int lvl, input int ptr);
        return (lvl - ptr - 1 + 16) % 8;
    endfunction

    function automatic logic [7:0] ref_resolve(input logic [7:0] irr,
                                               input logic [7:0] mask,
                                               input logic [7:0] isr,
                                               input logic       smm,
                                               input int         ptr);
        int best_req = 8;
        int best_isr = 8;
        int win = -1;
        logic [7:0] r;
        for (int lvl = 0; lvl < 8; lvl++) begin
            if (!smm && isr[lvl] && prio_of(lvl, ptr) < best_isr)
                best_isr = prio_of(lvl, ptr);
            if (irr[lvl] && !mask[lvl] && !(smm && isr[lvl]) && prio_of(lvl, ptr) < best_req) begin
                best_req = prio_of(lvl, ptr);
                win = lvl;
            end
        end
        r = '0;
        if (win >= 0 && best_req < best_isr) r[win] = 1'b1;
        return r;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_last  <= '0;
            m_older <= '0;
            m_nsamp <= 0;
            m_irr   <= '0;
            m_hpi   <= '0;
            m_int   <= 1'b0;
            m_ptr   <= 7;
        end else begin
            logic [7:0] cur, prv, nxt;
            // The IRR decision at this edge sees the pins as sampled one
            // edge ago, against the sample before that (all ones if none).
            cur = (m_nsamp >= 1) ? m_last : 8'h00;
            prv = (m_nsamp >= 2) ? m_older : 8'hFF;
            for (int b = 0; b < 8; b++) begin
                if (level_or_edge)            nxt[b] = cur[b] && !clear_request[b];
                else if (clear_request[b])    nxt[b] = 1'b0;
                else if (!cur[b])             nxt[b] = 1'b0;
                else if (!prv[b])             nxt[b] = 1'b1;
                else                          nxt[b] = m_irr[b];
            end
            if (!freeze) begin
                m_hpi <= ref_resolve(m_irr, interrupt_mask, in_service_register,
                                     special_mask_mode, m_ptr);
                m_int <= |ref_resolve(m_irr, interrupt_mask, in_service_register,
                                      special_mask_mode, m_ptr);
            end
            m_irr   <= nxt;
            m_older <= m_last;
            m_last  <= ir_in;
            m_nsamp <= (m_nsamp < 2) ? m_nsamp + 1 : 2;
            if (priority_load) m_ptr <= int'(priority_level);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_reset(input logic lvl_mode, input logic [7:0] pins);
        @(negedge clk);
        reset_n = 1'b0;
        ir_in = pins;
        level_or_edge = lvl_mode;
        interrupt_mask = '0;
        special_mask_mode = 1'b0;
        in_service_register = '0;
        clear_request = '0;
        priority_load = 1'b0;
        priority_level = '0;
        freeze = 1'b0;
        tick(2);
        reset_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        apply_reset(1'b0, 8'hFF);
        reset_n = 1'b0;
        tick(1);
        checks++;
        if (interrupt_request_register !== 8'h00 || highest_priority_interrupt !== 8'h00 || interrupt !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: irr=%h hpi=%h int=%b required 00 00 0",
                     interrupt_request_register, highest_priority_interrupt, interrupt);
        end
        reset_n = 1'b1;
        tick(10);
        checks++;
        if (interrupt_request_register !== 8'h00 || interrupt !== 1'b0) begin
            failures++;
            $display("FAIL high_through_reset: irr=%h int=%b required 00 0",
                     interrupt_request_register, interrupt);
        end
        ir_in = 8'hFE;
        tick(3);
        ir_in = 8'hFF;
        tick(2);
        checks++;
        if (interrupt_request_register !== 8'h01 || highest_priority_interrupt !== 8'h00) begin
            failures++;
            $display("FAIL relatch_ir0: irr=%h hpi=%h required 01 00",
                     interrupt_request_register, highest_priority_interrupt);
        end
        tick(1);
        checks++;
        if (highest_priority_interrupt !== 8'h01) begin
            failures++;
            $display("FAIL relatch_hpi: hpi=%h required 01", highest_priority_interrupt);
        end
    endtask

    task automatic test_edge_latch;
        apply_reset(1'b0, 8'h00);
        tick(4);
        ir_in = 8'h24;
        tick(2);
        checks++;
        if (interrupt_request_register !== 8'h24 || interrupt !== 1'b0) begin
            failures++;
            $display("FAIL edge_latency2: irr=%h int=%b required 24 0",
                     interrupt_request_register, interrupt);
        end
        tick(1);
        checks++;
        if (interrupt !== 1'b1 || highest_priority_interrupt !== 8'h04) begin
            failures++;
            $display("FAIL edge_latency3: int=%b hpi=%h required 1 04",
                     interrupt, highest_priority_interrupt);
        end
        clear_request = 8'h04;
        tick(1);
        clear_request = 8'h00;
        checks++;
        if (interrupt_request_register !== 8'h20) begin
            failures++;
            $display("FAIL clear_irr: irr=%h required 20", interrupt_request_register);
        end
        tick(1);
        checks++;
        if (highest_priority_interrupt !== 8'h20) begin
            failures++;
            $display("FAIL clear_hpi: hpi=%h required 20", highest_priority_interrupt);
        end
    endtask

    task automatic test_nesting;
        apply_reset(1'b1, 8'h00);
        ir_in = 8'h21;
        in_service_register = 8'h08;
        tick(3);
        checks++;
        if (highest_priority_interrupt !== 8'h01) begin
            failures++;
            $display("FAIL nest_higher: hpi=%h required 01", highest_priority_interrupt);
        end
        in_service_register = 8'h01;
        tick(1);
        checks++;
        if (highest_priority_interrupt !== 8'h00 || interrupt !== 1'b0) begin
            failures++;
            $display("FAIL nest_blocked: hpi=%h int=%b required 00 0",
                     highest_priority_interrupt, interrupt);
        end
        special_mask_mode = 1'b1;
        tick(1);
        checks++;
        if (highest_priority_interrupt !== 8'h20) begin
            failures++;
            $display("FAIL nest_smm: hpi=%h required 20", highest_priority_interrupt);
        end
    endtask

    task automatic test_rotation;
        apply_reset(1'b1, 8'h00);
        ir_in = 8'h41;
        priority_load = 1'b1;
        priority_level = 3'd4;
        tick(1);
        priority_load = 1'b0;
        tick(3);
        checks++;
        if (highest_priority_interrupt !== 8'h40) begin
            failures++;
            $display("FAIL rot_ptr4: hpi=%h required 40", highest_priority_interrupt);
        end
        priority_load = 1'b1;
        priority_level = 3'd7;
        tick(1);
        priority_load = 1'b0;
        tick(1);
        checks++;
        if (highest_priority_interrupt !== 8'h01) begin
            failures++;
            $display("FAIL rot_ptr7: hpi=%h required 01", highest_priority_interrupt);
        end
        interrupt_mask = 8'h01;
        tick(1);
        checks++;
        if (highest_priority_interrupt !== 8'h40 || interrupt_request_register !== 8'h41) begin
            failures++;
            $display("FAIL rot_mask: hpi=%h irr=%h required 40 41",
                     highest_priority_interrupt, interrupt_request_register);
        end
    endtask

    task automatic test_freeze;
        apply_reset(1'b0, 8'h00);
        tick(3);
        ir_in = 8'h04;
        tick(3);
        checks++;
        if (highest_priority_interrupt !== 8'h04) begin
            failures++;
            $display("FAIL freeze_setup: hpi=%h required 04", highest_priority_interrupt);
        end
        freeze = 1'b1;
        ir_in = 8'h05;
        tick(3);
        checks++;
        if (highest_priority_interrupt !== 8'h04 || interrupt_request_register !== 8'h05) begin
            failures++;
            $display("FAIL freeze_hold: hpi=%h irr=%h required 04 05",
                     highest_priority_interrupt, interrupt_request_register);
        end
        freeze = 1'b0;
        tick(1);
        checks++;
        if (highest_priority_interrupt !== 8'h01) begin
            failures++;
            $display("FAIL freeze_release: hpi=%h required 01", highest_priority_interrupt);
        end
    endtask

    task automatic test_level;
        apply_reset(1'b1, 8'h00);
        ir_in = 8'h80;
        tick(3);
        checks++;
        if (interrupt_request_register !== 8'h80 || interrupt !== 1'b1) begin
            failures++;
            $display("FAIL level_set: irr=%h int=%b required 80 1",
                     interrupt_request_register, interrupt);
        end
        ir_in = 8'h00;
        tick(3);
        checks++;
        if (interrupt_request_register !== 8'h00 || interrupt !== 1'b0) begin
            failures++;
            $display("FAIL level_drop: irr=%h int=%b required 00 0",
                     interrupt_request_register, interrupt);
        end
        ir_in = 8'h80;
        tick(3);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (interrupt_request_register !== 8'h00 || highest_priority_interrupt !== 8'h00 || interrupt !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: irr=%h hpi=%h int=%b required 00 00 0",
                     interrupt_request_register, highest_priority_interrupt, interrupt);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_random;
        int errs = 0;
        apply_reset(1'b0, 8'h00);
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            checks++;
            if (interrupt_request_register !== m_irr || highest_priority_interrupt !== m_hpi || interrupt !== m_int) begin
                failures++;
                if (errs < 10)
                    $display("FAIL random_cyc%0d: irr=%h hpi=%h int=%b required %h %h %b",
                             cyc, interrupt_request_register, highest_priority_interrupt,
                             interrupt, m_irr, m_hpi, m_int);
                errs++;
            end
            if ($urandom_range(0, 2) == 0) ir_in = ir_in ^ (8'h01 << $urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) ir_in = 8'($urandom);
            if ($urandom_range(0, 29) == 0) level_or_edge = ~level_or_edge;
            if ($urandom_range(0, 9) == 0) interrupt_mask = 8'($urandom) & 8'($urandom);
            case ($urandom_range(0, 3))
                0:       in_service_register = 8'h00;
                1:       in_service_register = 8'h01 << $urandom_range(0, 7);
                2:       in_service_register = 8'($urandom);
                default: ;
            endcase
            special_mask_mode = ($urandom_range(0, 3) == 0);
            clear_request = ($urandom_range(0, 3) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
            priority_load = ($urandom_range(0, 7) == 0);
            priority_level = 3'($urandom);
            freeze = ($urandom_range(0, 4) == 0);
        end
    endtask

    initial begin
        #2 reset_n = 1'b0;
        test_reset();
        test_edge_latch();
        test_nesting();
        test_rotation();
        test_freeze();
        test_level();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
